mesh_drain_arbiter: RTL and testbench

- Round-robin scheduler that drains the mesh output terminals (one pending flag and one head packet per terminal) into a single registered output stream.
- Drives the per-terminal pop strobes back into the mesh and shares the single output channel fairly among all terminals.
- Sits between the mesh DUT outputs and the checker/scoreboard sink; also usable as a reusable terminal drain in the RTL top.

---
 rtl/mesh_drain_arbiter.sv | 79 +++++++
 tb/tb_mesh_drain_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mesh_drain_arbiter.sv
// Round-robin drain of the mesh output terminals into one registered output stream.
// Terminal pops are combinational. The packet they select lands in the output register one cycle later.
module mesh_drain_arbiter #(
   parameter int ROWS    = 4,
   parameter int COLUMS  = 4,
   parameter int pckg_sz = 40,
   parameter int NTERM   = ROWS*2 + COLUMS*2,
   parameter int IDW     = $clog2(NTERM)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NTERM-1:0]   port_mask,
   input  logic               pndng [NTERM],
   input  logic [pckg_sz-1:0] data_out [NTERM],
   output logic               pop [NTERM],
   output logic               out_valid,
   input  logic               out_ready,
   output logic [pckg_sz-1:0] out_data,
   output logic [IDW-1:0]     out_src,
   output logic [31:0]        pkt_cnt,
   output logic               busy
);

   logic [NTERM-1:0] req;
   logic [IDW-1:0]   last;
   logic             slot_free;
   logic             gnt_vld;
   logic [IDW-1:0]   gnt_idx;

   assign slot_free = !out_valid || out_ready;

   always_comb begin
      for (int k = 0; k < NTERM; k++) req[k] = pndng[k] && port_mask[k];
   end

   assign busy = out_valid || (|req);

   // Scan starts at last+1 and wraps, so the most recent winner has the lowest priority.
   always_comb begin
      int k;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      k       = 0;
      if (!reset && enable && slot_free) begin
         for (int i = 1; i <= NTERM; i++) begin
            k = (int'(last) + i) % NTERM;
            if (!gnt_vld && req[k]) begin
               gnt_vld = 1'b1;
               gnt_idx = IDW'(k);
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NTERM; k++) pop[k] = gnt_vld && (gnt_idx == IDW'(k));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         pkt_cnt   <= '0;
         last      <= IDW'(NTERM-1);
      end else if (gnt_vld) begin
         // A grant also covers the accept-and-replace case: the slot was free.
         out_valid <= 1'b1;
         out_data  <= data_out[gnt_idx];
         out_src   <= gnt_idx;
         last      <= gnt_idx;
         pkt_cnt   <= pkt_cnt + 32'd1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mesh_drain_arbiter.sv
// Bench for mesh_drain_arbiter: directed scenarios followed by random traffic.
// A transaction-level reference model checks every cycle.
module tb_mesh_drain_arbiter;
   localparam int NT = 16;
   localparam int PW = 40;

   logic          clk = 1'b0;
   logic          reset, enable, out_ready;
   logic [NT-1:0] port_mask;
   logic          pndng [NT];
   logic [PW-1:0] data_out [NT];
   logic          pop [NT];
   logic          out_valid, busy;
   logic [PW-1:0] out_data;
   logic [3:0]    out_src;
   logic [31:0]   pkt_cnt;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   bit            m_valid;
   logic [PW-1:0] m_data;
   int            m_src;
   int unsigned   m_cnt;
   int            m_last;

   mesh_drain_arbiter dut (
      .clk(clk), .reset(reset), .enable(enable), .port_mask(port_mask),
      .pndng(pndng), .data_out(data_out), .pop(pop), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
      .pkt_cnt(pkt_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The winner is the requester nearest after the previous winner in circular order.
   function automatic int model_grant();
      int best = -1;
      int bd   = NT;
      if (reset || !enable || (m_valid && !out_ready)) return -1;
      for (int k = 0; k < NT; k++) begin
         if (pndng[k] && port_mask[k]) begin
            int d;
            d = (k - m_last - 1 + 2*NT) % NT;
            if (d < bd) begin
               bd   = d;
               best = k;
            end
         end
      end
      return best;
   endfunction

   // Check at the negedge, then advance the model at the posedge. Control returns at posedge+1.
   task automatic cyc();
      int            g;
      logic [NT-1:0] ep, op, rq;
      @(negedge clk);
      g  = model_grant();
      ep = '0;
      if (g >= 0) ep[g] = 1'b1;
      for (int k = 0; k < NT; k++) begin
         op[k] = pop[k];
         rq[k] = pndng[k] && port_mask[k];
      end
      chk("pop", 64'(op), 64'(ep));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         chk("out_data", 64'(out_data), 64'(m_data));
         chk("out_src", 64'(out_src), 64'(m_src));
      end
      chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
      chk("busy", 64'(busy), 64'(m_valid || (|rq)));
      @(posedge clk);
      if (reset) begin
         m_valid = 0; m_data = '0; m_src = 0; m_cnt = 0; m_last = NT-1;
      end else if (g >= 0) begin
         m_valid = 1; m_data = data_out[g]; m_src = g; m_last = g; m_cnt++;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic set_pndng(input logic [NT-1:0] v);
      for (int k = 0; k < NT; k++) pndng[k] = v[k];
   endtask

   initial begin
      logic [63:0] rnd;
      m_valid = 0; m_data = '0; m_src = 0; m_cnt = 0; m_last = NT-1;
      reset = 1; enable = 1; out_ready = 1; port_mask = '1;
      set_pndng('0);
      for (int k = 0; k < NT; k++) data_out[k] = {8'hD0 + 8'(k), 32'h1000_0000 + k};
      #1;
      cyc(); cyc();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_src", 64'(out_src), 64'd0);
      chk("rst_cnt", 64'(pkt_cnt), 64'd0);
      reset = 0;

      // Single packet from terminal 5.
      pndng[5] = 1; data_out[5] = 40'hA5_0000_0001;
      cyc();
      pndng[5] = 0;
      chk("t5_valid", 64'(out_valid), 64'd1);
      chk("t5_data", 64'(out_data), 64'hA5_0000_0001);
      chk("t5_src", 64'(out_src), 64'd5);
      chk("t5_cnt", 64'(pkt_cnt), 64'd1);
      cyc();

      // Full-load fairness after a fresh reset: winners are 0..15 then 0.
      reset = 1; cyc(); reset = 0;
      set_pndng('1);
      for (int i = 0; i < 17; i++) begin
         cyc();
         chk("rr_src", 64'(out_src), 64'(i % NT));
         if (i == 15) chk("rr_cnt16", 64'(pkt_cnt), 64'd16);
      end

      // Stall while holding terminal 3, then release: terminal 7 follows at once.
      reset = 1; cyc(); reset = 0;
      set_pndng(16'h0008);
      cyc();
      set_pndng(16'h0088); out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_src", 64'(out_src), 64'd3);
         chk("stall_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1;
      cyc();
      chk("after_stall_src", 64'(out_src), 64'd7);

      // Mask everything off, then open terminal 9 only.
      port_mask = '0; set_pndng('1);
      cyc(); cyc(); cyc();
      chk("masked_valid", 64'(out_valid), 64'd0);
      port_mask = 16'h0200;
      cyc();
      chk("mask9_src", 64'(out_src), 64'd9);

      // Disable with a packet held: it drains and nothing new is granted.
      enable = 0; port_mask = '1;
      cyc();
      chk("dis_drain", 64'(out_valid), 64'd0);
      cyc();
      chk("dis_idle", 64'(out_valid), 64'd0);
      enable = 1;
      cyc();
      chk("reen_src", 64'(out_src), 64'd10);

      // Reset with a valid packet held and every terminal requesting.
      reset = 1;
      cyc();
      chk("rst2_valid", 64'(out_valid), 64'd0);
      chk("rst2_cnt", 64'(pkt_cnt), 64'd0);
      reset = 0;
      cyc();
      chk("rst2_first", 64'(out_src), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rnd = {$urandom, $urandom};
         set_pndng(16'(rnd));
         port_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '1;
         enable    = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         reset     = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NT; k++) begin
            rnd = {$urandom, $urandom};
            data_out[k] = rnd[PW-1:0];
         end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
